hazard_stall_ctrl: RTL
======================

HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 2, the number of downstream write-back stages checked (index 0 = ID/EX, 1 = EX/MEM, ...), range 1..4.
REQ-002 SHALL have parameter BRANCH_STALL, default 2, the fetch-hold cycles after a branch decodes, range 1..7.
REQ-003 SHALL have parameter REG_ADDR_W, default 5, the register-address width.
REQ-004 clk  input  1  single clock; all state on posedge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 instruction  input  32  instruction currently in IF/ID.
REQ-007 id_valid  input  1  IF/ID holds a real instruction; when 0, no hazard is detected.
REQ-008 stage_regwrite  input  NUM_STAGES  per-stage register-write enable.
REQ-009 stage_memread  input  NUM_STAGES  per-stage load flag.
REQ-010 stage_rd  input  NUM_STAGES*REG_ADDR_W  per-stage destination register, packed with stage 0 in the LSBs.
REQ-011 branch_resolve  input  1  branch outcome known; ends the branch hold early.
REQ-012 holdPC  output  1  freeze the PC.
REQ-013 holdIF_ID  output  1  freeze the IF/ID register.
REQ-014 bubble_ID_EX  output  1  insert a NOP into ID/EX.
REQ-015 flush_IF_ID  output  1  replace the IF/ID contents with a NOP.
REQ-016 stall_cycles  output  16  saturating count of cycles with holdPC=1.

Function
REQ-017 rs = instruction[25:21] SHALL always be checked; rt = instruction[20:16] SHALL be checked only for opcode 000000, 000100 (BEQ), 000101 (BNE) or 101011 (SW).
REQ-018 A source SHALL match stage i only when stage_regwrite[i]=1, stage_rd[i] equals the source, and the source is nonzero (register $0 never hazards).
REQ-019 data_hazard SHALL be the combinational OR of all stage matches, gated by id_valid.
REQ-020 States SHALL be IDLE, DATA, BRANCH, encoded in 2 bits.
REQ-021 In IDLE or DATA with data_hazard=1: next state DATA; holdPC=holdIF_ID=bubble_ID_EX=1 in the same cycle (zero latency).
REQ-022 In DATA with data_hazard=0: outputs low in that cycle; next state IDLE, or BRANCH if the instruction is BEQ/BNE.
REQ-023 In IDLE with BEQ/BNE, id_valid=1 and data_hazard=0: next state BRANCH and the counter loads BRANCH_STALL-1; outputs are low in that cycle so the branch advances.
REQ-024 In BRANCH: holdPC=1 and flush_IF_ID=1, holdIF_ID=0; the counter decrements each cycle; exit to IDLE after the cycle in which the count is 0, giving exactly BRANCH_STALL hold cycles.
REQ-025 branch_resolve=1 in BRANCH SHALL force IDLE on the next edge; the resolving cycle still holds.
REQ-026 Data hazards SHALL be ignored while in BRANCH, because IF/ID is being flushed.
REQ-027 stall_cycles SHALL increment on each edge where holdPC=1 and saturate at 16'hFFFF, never wrapping.
REQ-028 A data hazard that persists because a stage is draining SHALL keep the stall asserted with no gap cycle.

Reset
REQ-029 While rst=1, asynchronously: state=IDLE, branch counter=0, stall_cycles=0, and all hold, bubble and flush outputs 0.
REQ-030 Reset asserted mid-stall SHALL abort the stall; after deassertion, the first edge evaluates the current instruction afresh.

Configuration
REQ-031 Macro HAZARD_FWD_EN defined: a forwarding path exists, and only stage 0 matches with stage_memread[0]=1 (load-use) raise data_hazard.
REQ-032 Macro HAZARD_FWD_EN undefined: every qualifying stage match (REQ-018) raises data_hazard, and stage_memread is ignored.

Structure
REQ-033 Package hazard_pkg SHALL hold the opcode constants (RTYPE, BEQ, BNE, SW), the 2-bit state encoding and the default REG_ADDR_W.
REQ-034 One sub-module, hazard_cmp, SHALL be instantiated per stage; it takes rs, rt, rt_used, rd and regwrite, and outputs match.

Verification
REQ-035 NUM_STAGES=2, no FWD: stage0 regwrite=1 rd=8, instruction add rs=8 -> holdPC=holdIF_ID=bubble_ID_EX=1 in the same cycle; the stall continues while stage1 rd=8 and ends when it clears.
REQ-036 Instruction with rs=0 while stage0 rd=0 and regwrite=1 -> no stall; stall_cycles stays 0.
REQ-037 BEQ with no hazard, BRANCH_STALL=2 -> holdPC=flush_IF_ID=1 for exactly 2 cycles, then IDLE; branch_resolve in the first hold cycle -> only 1 hold cycle.
REQ-038 HAZARD_FWD_EN: stage0 rd=9 regwrite=1 memread=0 with rs=9 -> no stall; the same case with memread=1 -> 1-cycle stall.
REQ-039 rst pulsed during the second BRANCH cycle -> all outputs 0 immediately; stall_cycles=0.
REQ-040 Force stall_cycles to 16'hFFFE, then hold for 3 cycles -> count reads 16'hFFFF and does not wrap.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: opcode constants, stall FSM state encoding and default register-address width
package hazard_pkg;
  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101;
  localparam logic [5:0] SW = 6'b101011;
  localparam int REG_ADDR_W_DEF = 5;
  typedef enum logic [1:0] {IDLE = 2'b00, DATA = 2'b01, BRANCH = 2'b10} state_e;
endpackage

// File: rtl/hazard_cmp.sv
// hazard_cmp: one stage's source/destination compare; register 0 never matches
module hazard_cmp #(
  parameter int W = 5
) (
  input  logic [W-1:0] rs,
  input  logic [W-1:0] rt,
  input  logic         rt_used,
  input  logic [W-1:0] rd,
  input  logic         regwrite,
  output logic         match
);
  assign match = regwrite && (((rs == rd) && (rs != '0)) || (rt_used && (rt == rd) && (rt != '0)));
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: data-hazard stall and branch fetch-hold control with saturating stall counter.
// Define HAZARD_FWD_EN when forwarding exists so that only a stage-0 load-use raises a data hazard.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int BRANCH_STALL = 2,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [31:0]                      instruction,
  input  logic                             id_valid,
  input  logic [NUM_STAGES-1:0]            stage_regwrite,
  input  logic [NUM_STAGES-1:0]            stage_memread,
  input  logic [NUM_STAGES*REG_ADDR_W-1:0] stage_rd,
  input  logic                             branch_resolve,
  output logic                             holdPC,
  output logic                             holdIF_ID,
  output logic                             bubble_ID_EX,
  output logic                             flush_IF_ID,
  output logic [15:0]                      stall_cycles
);
  localparam logic [2:0] BR_INIT = 3'(BRANCH_STALL - 1);
  logic [5:0] op;
  logic [REG_ADDR_W-1:0] rs, rt;
  logic rt_used, is_br, data_hazard, dstall, flush, unused_bits;
  logic [NUM_STAGES-1:0] match;
  state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [15:0] stall_q;
  assign op = instruction[31:26];
  assign rs = REG_ADDR_W'(instruction[25:21]);
  assign rt = REG_ADDR_W'(instruction[20:16]);
  assign rt_used = op inside {RTYPE, BEQ, BNE, SW};
  assign is_br = op inside {BEQ, BNE};
  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_cmp
    hazard_cmp #(.W(REG_ADDR_W)) u_cmp (
      .rs(rs),
      .rt(rt),
      .rt_used(rt_used),
      .rd(stage_rd[i*REG_ADDR_W +: REG_ADDR_W]),
      .regwrite(stage_regwrite[i]),
      .match(match[i])
    );
  end
`ifdef HAZARD_FWD_EN
  assign data_hazard = id_valid & match[0] & stage_memread[0];
  assign unused_bits = ^{instruction[15:0], match, stage_memread};
`else
  assign data_hazard = id_valid & (|match);
  assign unused_bits = ^{instruction[15:0], stage_memread};
`endif
  // Data hazards are only honoured outside BRANCH since IF/ID is being flushed there.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    dstall = 1'b0;
    flush = 1'b0;
    case (state_q)
      IDLE, DATA: begin
        dstall = data_hazard;
        state_d = data_hazard ? DATA : (is_br && id_valid) ? BRANCH : IDLE;
        cnt_d = (!data_hazard && is_br && id_valid) ? BR_INIT : cnt_q;
      end
      BRANCH: begin
        flush = 1'b1;
        state_d = (branch_resolve || cnt_q == '0) ? IDLE : BRANCH;
        cnt_d = (branch_resolve || cnt_q == '0) ? '0 : cnt_q - 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  assign holdPC = ~rst & (dstall | flush);
  assign holdIF_ID = ~rst & dstall;
  assign bubble_ID_EX = ~rst & dstall;
  assign flush_IF_ID = ~rst & flush;
  assign stall_cycles = stall_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (holdPC && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    end
  end
endmodule
